ofdm_frame_builder: RTL and testbench

- Buffers a byte stream, then on `beginTX` emits one OFDM frame as a 64-slot frequency-domain sample stream: preamble symbol, FCH symbol, then `data_frame_size` data symbols.
- Output feeds an external IFFT and CP stage; the stream is usually written into an async FIFO.
- Single clock domain.

---
 rtl/ofdm_frame_builder_if.sv | 21 ++
 rtl/ofdm_frame_builder.sv | 185 ++++++++++++++++++
 tb/tb_ofdm_frame_builder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_frame_builder_if.sv
// Byte-in / sample-out stream bundle for the OFDM frame builder.
// slave = the builder itself, master = whoever feeds bytes and drains samples.
interface ofdm_frame_builder_if;
  logic        valid;
  logic [7:0]  in_data;
  logic        flag_ready_read;
  logic [15:0] out_data_i;
  logic [15:0] out_data_q;
  logic        tx_valid;
  logic        i_wayt_read_data;

  modport master (
    output valid, in_data, i_wayt_read_data,
    input  flag_ready_read, out_data_i, out_data_q, tx_valid
  );

  modport slave (
    input  valid, in_data, i_wayt_read_data,
    output flag_ready_read, out_data_i, out_data_q, tx_valid
  );
endinterface

// File: rtl/ofdm_frame_builder.sv
// Buffers bytes, then emits preamble, FCH and N data symbols as 64-slot I/Q streams.
// One-deep output register; tx_valid is gated by en and downstream ready so no slot is lost.
module ofdm_frame_builder #(
  parameter int MEMORY_SYZE = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               beginTX,
  input  logic [7:0]         data_frame_size,
  input  logic [3:0]         modulation,
  ofdm_frame_builder_if.slave io,
  output logic               done_transmit,
  output logic [3:0]         o_state_OFDM,
  output logic [7:0]         d_FCH_data,
  output logic [15:0]        d_in_fft_data_i,
  output logic [15:0]        d_in_fft_data_q,
  output logic [15:0]        d_fft_data_i,
  output logic [15:0]        d_fft_data_q,
  output logic               d_complete_fft
);
  localparam int DEPTH = 1 << MEMORY_SYZE;
  localparam logic [15:0] P8192 = 16'sd8192;
  localparam logic [15:0] N8192 = -16'sd8192;
  localparam logic [15:0] P5793 = 16'sd5793;
  localparam logic [15:0] N5793 = -16'sd5793;

  typedef enum logic [3:0] {
    IDLE = 4'd0, WAIT_DATA = 4'd1, PREAMBLE = 4'd2, FCH = 4'd3, DATA = 4'd4, DONE = 4'd5
  } state_t;
  state_t state, state_nxt;

  logic [7:0]             mem [DEPTH];
  logic [MEMORY_SYZE-1:0] wr_ptr, rd_ptr;
  logic [MEMORY_SYZE:0]   fill, fill_nxt;
  logic                   not_full, wr, pop;
  logic [2:0]             mod_q, bit_off;
  logic [7:0]             dfs_q, sym_cnt, cur_byte, bits;
  logic [5:0]             slot;
  logic [3:0]             off_sum;
  logic [15:0]            need, smp_i, smp_q;
  logic                   gen, is_null, is_pilot, is_data, starve, load, consume, done_go;
  logic                   out_full, out_last;

  function automatic logic [15:0] qam_level(input logic [1:0] v);
    case (v)
      2'b00:   return -16'sd7770;
      2'b01:   return -16'sd2590;
      2'b11:   return 16'sd2590;
      default: return 16'sd7770;
    endcase
  endfunction

  assign wr                 = en & io.valid & not_full;
  assign io.flag_ready_read = en & not_full;
  assign fill_nxt = fill + {{MEMORY_SYZE{1'b0}}, wr} - {{MEMORY_SYZE{1'b0}}, pop};
  assign need     = 16'(mod_q) * 16'(dfs_q) * 16'd6;

  assign gen      = (state == PREAMBLE) || (state == FCH) || (state == DATA);
  assign is_null  = (slot == 6'd0) || ((slot >= 6'd27) && (slot <= 6'd37));
  assign is_pilot = (slot == 6'd7) || (slot == 6'd21) || (slot == 6'd43) || (slot == 6'd57);
  assign is_data  = !is_null && !is_pilot;
  assign cur_byte = mem[rd_ptr];
  assign bits     = cur_byte >> bit_off;
  assign off_sum  = {1'b0, bit_off} + {1'b0, mod_q};

  // A data slot with nothing buffered waits rather than emitting garbage.
  assign starve  = (state == DATA) && is_data && (fill == '0);
  assign consume = en & out_full & io.i_wayt_read_data;
  assign load    = en & gen & !starve & (!out_full | consume);
  assign pop     = load & (state == DATA) & is_data & off_sum[3];
  assign done_go = en & (!out_full | consume);

  assign io.tx_valid    = consume;
  assign d_complete_fft = consume & out_last;
  assign d_fft_data_i   = io.out_data_i;
  assign d_fft_data_q   = io.out_data_q;
  assign o_state_OFDM   = state;

  always_comb begin
    smp_i = '0;
    smp_q = '0;
    if (is_pilot) begin
      smp_i = P8192;
    end else if (is_data) begin
      case (state)
        PREAMBLE: smp_i = slot[0] ? N8192 : P8192;
        FCH:      smp_i = d_FCH_data[bit_off] ? N8192 : P8192;
        default: begin
          case (mod_q)
            3'd1: smp_i = bits[0] ? N8192 : P8192;
            3'd2: begin
              smp_i = bits[0] ? N5793 : P5793;
              smp_q = bits[1] ? N5793 : P5793;
            end
            default: begin
              smp_i = qam_level(bits[1:0]);
              smp_q = qam_level(bits[3:2]);
            end
          endcase
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:      if (beginTX) state_nxt = WAIT_DATA;
        // A full buffer also releases the frame so oversized frames cannot deadlock.
        WAIT_DATA: if (32'(fill) >= 32'(need) || !not_full) state_nxt = PREAMBLE;
        PREAMBLE:  if (load && slot == 6'd63) state_nxt = FCH;
        FCH:       if (load && slot == 6'd63) state_nxt = DATA;
        DATA:      if (load && slot == 6'd63 && sym_cnt == dfs_q - 8'd1) state_nxt = DONE;
        DONE:      if (done_go) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= io.in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill            <= '0;
      not_full        <= 1'b0;
      mod_q           <= 3'd4;
      dfs_q           <= '0;
      d_FCH_data      <= '0;
      sym_cnt         <= '0;
      slot            <= '0;
      bit_off         <= '0;
      out_full        <= 1'b0;
      out_last        <= 1'b0;
      io.out_data_i   <= '0;
      io.out_data_q   <= '0;
      d_in_fft_data_i <= '0;
      d_in_fft_data_q <= '0;
      done_transmit   <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fill     <= fill_nxt;
      not_full <= (fill_nxt != (MEMORY_SYZE+1)'(DEPTH));

      if (en && state == IDLE && beginTX) begin
        mod_q         <= (modulation == 4'd1) ? 3'd1 : (modulation == 4'd2) ? 3'd2 : 3'd4;
        dfs_q         <= data_frame_size;
        d_FCH_data    <= data_frame_size;
        done_transmit <= 1'b0;
        sym_cnt       <= '0;
        slot          <= '0;
        bit_off       <= '0;
      end

      if (consume) out_full <= 1'b0;
      if (load) begin
        out_full      <= 1'b1;
        out_last      <= (slot == 6'd63);
        io.out_data_i <= smp_i;
        io.out_data_q <= smp_q;
        slot          <= slot + 6'd1;
        if (is_data && state == FCH)  bit_off <= bit_off + 3'd1;
        if (is_data && state == DATA) begin
          bit_off         <= off_sum[2:0];
          d_in_fft_data_i <= smp_i;
          d_in_fft_data_q <= smp_q;
        end
        if (slot == 6'd63 && state == DATA) sym_cnt <= sym_cnt + 8'd1;
      end

      if (state == DONE && done_go) done_transmit <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ofdm_frame_builder.sv
// Frame-level bench: table of frame scenarios checked against a slot/bitstream reference model.
`timescale 1ns/1ps
module tb_ofdm_frame_builder;
  localparam int MS    = 12;
  localparam int DEPTH = 1 << MS;

  logic        clk = 1'b0, reset = 1'b0, en = 1'b0, beginTX = 1'b0;
  logic [7:0]  data_frame_size = '0;
  logic [3:0]  modulation = '0;
  logic        done_transmit, d_complete_fft;
  logic [3:0]  o_state_OFDM;
  logic [7:0]  d_FCH_data;
  logic [15:0] d_in_fft_data_i, d_in_fft_data_q, d_fft_data_i, d_fft_data_q;

  ofdm_frame_builder_if io();

  ofdm_frame_builder #(.MEMORY_SYZE(MS)) dut (
    .clk(clk), .reset(reset), .en(en), .beginTX(beginTX),
    .data_frame_size(data_frame_size), .modulation(modulation), .io(io.slave),
    .done_transmit(done_transmit), .o_state_OFDM(o_state_OFDM), .d_FCH_data(d_FCH_data),
    .d_in_fft_data_i(d_in_fft_data_i), .d_in_fft_data_q(d_in_fft_data_q),
    .d_fft_data_i(d_fft_data_i), .d_fft_data_q(d_fft_data_q), .d_complete_fft(d_complete_fft)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mod; int dfs; int stall; logic [7:0] b0; int npre;
    int sym; int slot; int ei; int eq;
  } vec_t;

  int n_tests = 0, n_fail = 0;
  logic [7:0] mq[$];
  int exp_i[$], exp_q[$], got_i[$], got_q[$];
  int n_pulse = 0, mirr_err = 0;
  bit cap = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cap) begin
      if (io.tx_valid) begin
        got_i.push_back(int'($signed(io.out_data_i)));
        got_q.push_back(int'($signed(io.out_data_q)));
        if (d_fft_data_i !== io.out_data_i || d_fft_data_q !== io.out_data_q) mirr_err++;
      end
      if (d_complete_fft) n_pulse++;
    end
  end

  // Reference: consume bytes from the buffer model and lay out every slot of every symbol.
  task automatic model(input int mod, input int dfs);
    int m, nb, d, n, v, vi, vq;
    int lv[4];
    logic [7:0] fb[$];
    lv = '{-7770, -2590, 7770, 2590};
    m  = (mod == 1 || mod == 2) ? mod : 4;
    nb = 6 * m * dfs;
    for (int i = 0; i < nb; i++) fb.push_back(mq.pop_front());
    exp_i.delete();
    exp_q.delete();
    for (int s = 0; s < dfs + 2; s++) begin
      d = 0;
      for (int k = 0; k < 64; k++) begin
        vi = 0;
        vq = 0;
        if (k == 7 || k == 21 || k == 43 || k == 57) begin
          vi = 8192;
        end else if (!(k == 0 || (k >= 27 && k <= 37))) begin
          if (s == 0) vi = (k % 2 == 0) ? 8192 : -8192;
          else if (s == 1) vi = ((dfs >> (d % 8)) & 1) != 0 ? -8192 : 8192;
          else begin
            n = ((s - 2) * 48 + d) * m;
            v = 0;
            for (int j = 0; j < m; j++) v |= ((int'(fb[(n + j) / 8]) >> ((n + j) % 8)) & 1) << j;
            if (m == 1) vi = (v != 0) ? -8192 : 8192;
            else if (m == 2) begin
              vi = ((v & 1) != 0) ? -5793 : 5793;
              vq = ((v & 2) != 0) ? -5793 : 5793;
            end else begin
              vi = lv[v & 3];
              vq = lv[v >> 2];
            end
          end
          d++;
        end
        exp_i.push_back(vi);
        exp_q.push_back(vq);
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    io.valid   = 1'b1;
    io.in_data = b;
    if (mq.size() < DEPTH) mq.push_back(b);
    @(posedge clk); #1;
    io.valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input vec_t t, input string tag);
    int m, nb, cyc, mism, idx;
    m  = (t.mod == 1 || t.mod == 2) ? t.mod : 4;
    nb = 6 * m * t.dfs;
    en = 1'b1;
    io.i_wayt_read_data = 1'b1;
    for (int i = 0; i < nb && i < t.npre; i++) push_byte(i == 0 ? t.b0 : 8'($urandom));
    got_i.delete();
    got_q.delete();
    n_pulse  = 0;
    mirr_err = 0;
    cap      = 1'b1;
    modulation      = 4'(t.mod);
    data_frame_size = 8'(t.dfs);
    beginTX         = 1'b1;
    @(posedge clk); #1;
    beginTX = 1'b0;
    if (t.npre < nb) begin
      repeat (40) @(posedge clk);
      #1;
      check({tag, " wait_state"}, o_state_OFDM, 1);
      check({tag, " wait_quiet"}, got_i.size(), 0);
      for (int i = t.npre; i < nb; i++) push_byte(i == 0 ? t.b0 : 8'($urandom));
    end
    model(t.mod, t.dfs);
    cyc = 0;
    while (!done_transmit && cyc < 20000) begin
      case (t.stall)
        0: io.i_wayt_read_data = 1'b1;
        1: io.i_wayt_read_data = cyc[0];
        default: begin
          io.i_wayt_read_data = 1'($urandom);
          en = ($urandom_range(0, 3) != 0);
        end
      endcase
      // Requests outside IDLE must not disturb the running frame.
      if (cyc == 100) begin
        beginTX         = 1'b1;
        modulation      = 4'($urandom);
        data_frame_size = 8'($urandom);
      end else beginTX = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    beginTX = 1'b0;
    en = 1'b1;
    io.i_wayt_read_data = 1'b1;
    cap = 1'b0;
    check({tag, " done"}, done_transmit, 1);
    check({tag, " idle"}, o_state_OFDM, 0);
    check({tag, " count"}, got_i.size(), (t.dfs + 2) * 64);
    mism = 0;
    for (int i = 0; i < got_i.size() && i < exp_i.size(); i++)
      if (got_i[i] != exp_i[i] || got_q[i] != exp_q[i]) mism++;
    check({tag, " seq_mismatches"}, mism, 0);
    check({tag, " complete_pulses"}, n_pulse, t.dfs + 2);
    check({tag, " mirror"}, mirr_err, 0);
    check({tag, " fch_byte"}, d_FCH_data, t.dfs);
    if (t.sym >= 0) begin
      idx = t.sym * 64 + t.slot;
      check({tag, " spot_i"}, idx < got_i.size() ? got_i[idx] : 99999, t.ei);
      check({tag, " spot_q"}, idx < got_q.size() ? got_q[idx] : 99999, t.eq);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    vec_t fullv;
    tbl = '{
      '{4, 10, 0, 8'h1B, 999, 2, 1,  2590,  7770},
      '{4, 10, 1, 8'h1B, 999, 2, 7,  8192,     0},
      '{4, 10, 0, 8'h1B, 999, 2, 0,     0,     0},
      '{1,  2, 0, 8'h01, 999, 2, 1, -8192,     0},
      '{1,  2, 1, 8'h01, 999, 2, 2,  8192,     0},
      '{1,  2, 0, 8'h01, 999, 1, 1,  8192,     0},
      '{1,  2, 2, 8'h01, 999, 1, 2, -8192,     0},
      '{2,  3, 0, 8'h02, 999, 2, 1,  5793, -5793},
      '{7,  1, 0, 8'h1B, 999, 2, 1,  2590,  7770},
      '{4,  1, 0, 8'h1B,   5, 2, 1,  2590,  7770},
      '{2,  4, 2, 8'h00, 999, 0, 3, -8192,     0},
      '{4,  5, 2, 8'hE4, 999, 2, 1, -7770, -2590}
    };
    io.valid = 1'b0;
    io.in_data = '0;
    io.i_wayt_read_data = 1'b1;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_zero", int'(|{io.tx_valid, io.flag_ready_read, done_transmit, d_complete_fft,
          d_FCH_data, io.out_data_i, io.out_data_q, d_in_fft_data_i, d_in_fft_data_q,
          d_fft_data_i, d_fft_data_q}), 0);
    check("reset_state", o_state_OFDM, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", io.flag_ready_read, 1);

    for (int i = 0; i < 12; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Every buffered byte was consumed, so a 24-byte frame must wait.
    modulation = 4'd4;
    data_frame_size = 8'd1;
    beginTX = 1'b1;
    @(posedge clk); #1;
    beginTX = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("empty_after_frames", o_state_OFDM, 1);

    do_reset();
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
    check("full_flag", io.flag_ready_read, 0);
    push_byte(8'hA5);
    check("still_full", io.flag_ready_read, 0);
    fullv = '{1, 1, 0, 8'h00, 999, -1, 0, 0, 0};
    run_frame(fullv, "full");
    check("ready_after_drain", io.flag_ready_read, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
